// File: rtl/vx_scoreboard_if.sv
// Decode / writeback / clear bundle between the pipeline front end and the per-warp scoreboard.
// master drives decode, writeback and clear requests; slave is the scoreboard itself.
interface vx_scoreboard_if #(
  parameter int NW = 8
);
  localparam int NW_M1 = $clog2(NW) - 1;

  logic             in_decode_valid;
  logic [NW_M1:0]   in_decode_warp_num;
  logic [4:0]       in_decode_src1;
  logic [4:0]       in_decode_src2;
  logic [4:0]       in_decode_dest;
  logic [1:0]       in_decode_wb;
  logic             in_decode_is_csr;
  logic             in_fwd_stall;
  logic             in_writeback_valid;
  logic [NW_M1:0]   in_writeback_warp_num;
  logic [4:0]       in_writeback_dest;
  logic             in_csr_done;
  logic             in_clear_valid;
  logic [NW_M1:0]   in_clear_warp_num;
  logic             out_issue_ready;
  logic             out_stall;
  logic [NW-1:0]    out_warp_idle;
  logic [31:0]      out_stall_cycles;

  modport master (
    output in_decode_valid, in_decode_warp_num, in_decode_src1, in_decode_src2,
           in_decode_dest, in_decode_wb, in_decode_is_csr, in_fwd_stall,
           in_writeback_valid, in_writeback_warp_num, in_writeback_dest,
           in_csr_done, in_clear_valid, in_clear_warp_num,
    input  out_issue_ready, out_stall, out_warp_idle, out_stall_cycles
  );

  modport slave (
    input  in_decode_valid, in_decode_warp_num, in_decode_src1, in_decode_src2,
           in_decode_dest, in_decode_wb, in_decode_is_csr, in_fwd_stall,
           in_writeback_valid, in_writeback_warp_num, in_writeback_dest,
           in_csr_done, in_clear_valid, in_clear_warp_num,
    output out_issue_ready, out_stall, out_warp_idle, out_stall_cycles
  );
endinterface

// File: rtl/vx_scoreboard.sv
// Per-warp register scoreboard: tracks in-flight register writes and CSR ops,
// holds decode on RAW/WAW/CSR hazards and counts stall cycles.
module vx_scoreboard #(
  parameter int          NW             = 8,
  parameter int          NR             = 32,
  parameter logic [31:0] STALL_CNT_INIT = 32'h0
) (
  input  logic           clk,
  input  logic           reset,
  vx_scoreboard_if.slave sb
);
  localparam int         WW       = $clog2(NW);
  localparam logic [1:0] NO_WB    = 2'b00;
  localparam logic [4:0] ZERO_REG = 5'd0;

  logic [NW-1:0][NR-1:0] pending_rows;
  logic [NW-1:0]         csr_rows;
  logic [NW-1:0]         idle_vec;
  logic [NR-1:0]         dec_row;
  logic                  haz_src1, haz_src2, haz_dest, haz_csr, hazard;
  logic                  issue_ready, issue_fire, stall;
  logic [31:0]           stall_cnt_reg;

  // Hazard check looks only at registered state; writebacks this cycle do not bypass.
  assign dec_row  = pending_rows[sb.in_decode_warp_num];
  assign haz_src1 = (sb.in_decode_src1 != ZERO_REG) && dec_row[sb.in_decode_src1];
  assign haz_src2 = (sb.in_decode_src2 != ZERO_REG) && dec_row[sb.in_decode_src2];
  assign haz_dest = (sb.in_decode_wb != NO_WB) && (sb.in_decode_dest != ZERO_REG)
                    && dec_row[sb.in_decode_dest];
  assign haz_csr  = sb.in_decode_is_csr && csr_rows[sb.in_decode_warp_num];
  assign hazard   = haz_src1 || haz_src2 || haz_dest || haz_csr;

  assign issue_ready = !hazard && !sb.in_fwd_stall;
  assign issue_fire  = sb.in_decode_valid && issue_ready;
  assign stall       = sb.in_decode_valid && !issue_ready;

  for (genvar gi = 0; gi < NW; gi++) begin : g_warp
    logic [NR-1:0] pending_reg;
    logic          csr_pending_reg;
    logic          hit_dec, hit_wb, hit_clr;
    logic [NR-1:0] set_mask, wb_mask;

    assign hit_dec = issue_fire && (sb.in_decode_warp_num == WW'(gi));
    assign hit_wb  = sb.in_writeback_warp_num == WW'(gi);
    assign hit_clr = sb.in_clear_valid && (sb.in_clear_warp_num == WW'(gi));

    assign set_mask = (hit_dec && (sb.in_decode_wb != NO_WB) && (sb.in_decode_dest != ZERO_REG))
                      ? (NR'(1) << sb.in_decode_dest) : '0;
    assign wb_mask  = (hit_wb && sb.in_writeback_valid)
                      ? (NR'(1) << sb.in_writeback_dest) : '0;

    // Clear beats issue, and an issue set beats a writeback clear of the same bit.
    always_ff @(posedge clk) begin
      if (reset || hit_clr) begin
        pending_reg     <= '0;
        csr_pending_reg <= 1'b0;
      end else begin
        pending_reg <= (pending_reg & ~wb_mask) | set_mask;
        if (hit_dec && sb.in_decode_is_csr)
          csr_pending_reg <= 1'b1;
        else if (hit_wb && sb.in_csr_done)
          csr_pending_reg <= 1'b0;
      end
    end

    assign pending_rows[gi] = pending_reg;
    assign csr_rows[gi]     = csr_pending_reg;
    assign idle_vec[gi]     = !(|pending_reg) && !csr_pending_reg;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_reg <= STALL_CNT_INIT;
    else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign sb.out_issue_ready  = issue_ready;
  assign sb.out_stall        = stall;
  assign sb.out_warp_idle    = idle_vec;
  assign sb.out_stall_cycles = stall_cnt_reg;
endmodule
